// File: rtl/jtag_master_pkg.sv
// jtag_master_pkg
//   Shared types and constants for the JTAG initiator.
//   - op_e     : command opcodes presented on cmd_op
//   - state_e  : sequencer states of jtag_master (also exported on dbg_state)
//   - TMS_*    : fixed TMS lists, bit 0 is sent on the first TCK
//   - clamp_len: maps a requested shift length onto 1..max_bits
package jtag_master_pkg;

    typedef enum logic [1:0] {
        OP_TAP_RESET = 2'd0,
        OP_SHIFT_IR  = 2'd1,
        OP_SHIFT_DR  = 2'd2,
        OP_RUN_IDLE  = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HEAD  = 3'd1,
        S_SHIFT = 3'd2,
        S_TAIL  = 3'd3,
        S_RSP   = 3'd4
    } state_e;

    // Run-Test/Idle -> Select-DR -> Capture-DR -> Shift-DR
    localparam logic [2:0] TMS_DR_HDR  = 3'b001;
    // Run-Test/Idle -> Select-DR -> Select-IR -> Capture-IR -> Shift-IR
    localparam logic [3:0] TMS_IR_HDR  = 4'b0011;
    // Exit1 -> Update -> Run-Test/Idle
    localparam logic [1:0] TMS_TRAILER = 2'b01;
    // Five ones reach Test-Logic-Reset from anywhere, the final zero parks in Run-Test/Idle
    localparam logic [5:0] TMS_RESET   = 6'b011111;

    // A zero-length scan still shifts one bit; anything longer than the data
    // buses is cut to the bus width.
    function automatic logic [6:0] clamp_len(input logic [6:0] len, input int max_bits);
        if (len == 7'd0) begin
            return 7'd1;
        end
        if (int'(len) > max_bits) begin
            return 7'(max_bits);
        end
        return len;
    endfunction

endpackage

// File: rtl/jtag_tck_gen.sv
// jtag_tck_gen
//   TCK divider. While en is high, TCK runs with CLK_DIV sys_clock cycles
//   per half-period, low phase first. rise/fall are single-cycle strobes
//   asserted on the last sys_clock cycle of the low/high phase, i.e. on the
//   cycle whose closing edge makes TCK rise/fall. With en low the divider is
//   cleared and TCK is held low, so the next enable starts a fresh low phase.
// Ports:
//   sys_clock, reset : clock, async active-high reset
//   en               : run the divider
//   tck              : registered TCK (doubles as the phase flag)
//   rise, fall       : phase-end strobes
module jtag_tck_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic sys_clock,
    input  logic reset,
    input  logic en,
    output logic tck,
    output logic rise,
    output logic fall
);

    localparam int              CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0]   LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;
    logic          at_end;

    assign at_end = (cnt == LAST);
    assign rise   = en && !tck && at_end;
    assign fall   = en &&  tck && at_end;

    always_ff @(posedge sys_clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            tck <= 1'b0;
        end else if (!en) begin
            cnt <= '0;
            tck <= 1'b0;
        end else if (at_end) begin
            cnt <= '0;
            tck <= ~tck;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/jtag_master.sv
// jtag_master
//   Command-driven JTAG initiator. Each command walks the target TAP from
//   Run-Test/Idle back to Run-Test/Idle (TAP_RESET works from any state) and
//   returns the TDO bits captured during the shift.
// Ports:
//   sys_clock, reset          : clock, async active-high reset
//   cmd_valid/cmd_ready       : command handshake
//   cmd_op, cmd_len, cmd_data : opcode, length, TDI bits (LSB first)
//   rsp_valid/rsp_ready       : response handshake
//   rsp_data                  : captured TDO bits (LSB first), zero above L
//   jtag_tck/tms/tdi/tdo      : JTAG pins
//   dbg_state                 : current sequencer state (state_e encoding)
//
// Handshakes: a transfer happens on a sys_clock edge where valid && ready are
// both high. The producer holds valid and payload until that edge; the
// consumer may hold ready low indefinitely. cmd_ready is high only in S_IDLE;
// rsp_valid is high only in S_RSP with rsp_data frozen until the transfer.
module jtag_master
    import jtag_master_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int MAX_BITS = 64
) (
    input  logic                sys_clock,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [6:0]          cmd_len,
    input  logic [MAX_BITS-1:0] cmd_data,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [MAX_BITS-1:0] rsp_data,
    output logic                jtag_tck,
    output logic                jtag_tms,
    output logic                jtag_tdi,
    input  logic                jtag_tdo,
    output logic [2:0]          dbg_state
);

    state_e              state;
    logic [5:0]          tms_sr;     // remaining TMS bits of the current head/tail list
    logic [6:0]          tck_left;   // TCKs left in the current state, counting the one in progress
    logic [6:0]          shift_len;  // clamped shift length
    logic [MAX_BITS-1:0] data_sr;    // TDI bits, bit 0 is the one on the pin
    logic [MAX_BITS-1:0] cap_mask;   // one-hot position for the next captured TDO bit

    logic tck_en;
    logic tck_rise;
    logic tck_fall;

    assign tck_en    = (state == S_HEAD) || (state == S_SHIFT) || (state == S_TAIL);
    assign dbg_state = state;

    jtag_tck_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tck_gen (
        .sys_clock (sys_clock),
        .reset     (reset),
        .en        (tck_en),
        .tck       (jtag_tck),
        .rise      (tck_rise),
        .fall      (tck_fall)
    );

    // TMS/TDI for a TCK are loaded on the edge that starts its low phase:
    // the accept edge for the first TCK, the falling edge for all others.
    // TDO is captured on the edge that raises TCK, i.e. the value the target
    // drove after the previous falling edge.
    always_ff @(posedge sys_clock or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            jtag_tms  <= 1'b1;
            jtag_tdi  <= 1'b0;
            tms_sr    <= '0;
            tck_left  <= '0;
            shift_len <= '0;
            data_sr   <= '0;
            cap_mask  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        cmd_ready <= 1'b0;
                        rsp_data  <= '0;
                        jtag_tdi  <= 1'b0;
                        data_sr   <= cmd_data;
                        shift_len <= clamp_len(cmd_len, MAX_BITS);
                        case (op_e'(cmd_op))
                            OP_TAP_RESET: begin
                                state    <= S_TAIL;
                                jtag_tms <= TMS_RESET[0];
                                tms_sr   <= 6'(TMS_RESET) >> 1;
                                tck_left <= 7'd6;
                            end
                            OP_SHIFT_IR: begin
                                state    <= S_HEAD;
                                jtag_tms <= TMS_IR_HDR[0];
                                tms_sr   <= 6'(TMS_IR_HDR) >> 1;
                                tck_left <= 7'd4;
                            end
                            OP_SHIFT_DR: begin
                                state    <= S_HEAD;
                                jtag_tms <= TMS_DR_HDR[0];
                                tms_sr   <= 6'(TMS_DR_HDR) >> 1;
                                tck_left <= 7'd3;
                            end
                            OP_RUN_IDLE: begin
                                tms_sr   <= '0;
                                tck_left <= cmd_len;
                                if (cmd_len == 7'd0) begin
                                    // nothing to clock: answer immediately, TMS untouched
                                    state     <= S_RSP;
                                    rsp_valid <= 1'b1;
                                end else begin
                                    state    <= S_TAIL;
                                    jtag_tms <= 1'b0;
                                end
                            end
                            default: state <= S_IDLE;
                        endcase
                    end
                end

                S_HEAD: begin
                    if (tck_fall) begin
                        if (tck_left == 7'd1) begin
                            state    <= S_SHIFT;
                            tck_left <= shift_len;
                            cap_mask <= MAX_BITS'(1);
                            jtag_tms <= (shift_len == 7'd1);
                            jtag_tdi <= data_sr[0];
                        end else begin
                            tck_left <= tck_left - 7'd1;
                            jtag_tms <= tms_sr[0];
                            tms_sr   <= tms_sr >> 1;
                        end
                    end
                end

                S_SHIFT: begin
                    if (tck_rise) begin
                        if (jtag_tdo) begin
                            rsp_data <= rsp_data | cap_mask;
                        end
                        cap_mask <= cap_mask << 1;
                    end
                    if (tck_fall) begin
                        if (tck_left == 7'd1) begin
                            state    <= S_TAIL;
                            tck_left <= 7'd2;
                            jtag_tms <= TMS_TRAILER[0];
                            tms_sr   <= 6'(TMS_TRAILER) >> 1;
                            jtag_tdi <= 1'b0;
                        end else begin
                            tck_left <= tck_left - 7'd1;
                            // the bit about to go out is the last one: leave Shift on it
                            jtag_tms <= (tck_left == 7'd2);
                            jtag_tdi <= data_sr[1];
                            data_sr  <= data_sr >> 1;
                        end
                    end
                end

                S_TAIL: begin
                    if (tck_fall) begin
                        if (tck_left == 7'd1) begin
                            // every list ends with TMS=0, which stays on the pin while idle
                            state     <= S_RSP;
                            rsp_valid <= 1'b1;
                        end else begin
                            tck_left <= tck_left - 7'd1;
                            jtag_tms <= tms_sr[0];
                            tms_sr   <= tms_sr >> 1;
                        end
                    end
                end

                S_RSP: begin
                    if (rsp_ready) begin
                        state     <= S_IDLE;
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                    end
                end

                default: begin
                    state     <= S_IDLE;
                    cmd_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/jtag_master.md
# jtag_master

Harness-side JTAG initiator that drives the TAP of the debug-enabled SoC core from a simple command/response interface. It generates TCK from `sys_clock`, walks the TAP state machine for reset, IR scans, DR scans and idle clocking, and returns the TDO bits captured during each scan. It sits in the FPGA shell beside the PLL and core, connected to their `jtag_tck`/`jtag_tms`/`jtag_tdi`/`jtag_tdo` pins, and serves on-chip bring-up and self-test logic that needs no external probe.

## Interface
- `CLK_DIV`, default 4: `sys_clock` cycles per TCK half-period; legal values are 1 or more.
- `MAX_BITS`, default 64: maximum scan length and width of the data buses.
- `sys_clock` input, 1 bit: the single clock.
- `reset` input, 1 bit: asynchronous, active-high.
- `cmd_valid` input, 1 bit: a command is offered.
- `cmd_ready` output, 1 bit: the block can accept a command.
- `cmd_op` input, 2 bits: 0 = TAP_RESET, 1 = SHIFT_IR, 2 = SHIFT_DR, 3 = RUN_IDLE.
- `cmd_len` input, 7 bits: scan bit count, or TCK count for RUN_IDLE.
- `cmd_data` input, MAX_BITS: TDI bits, LSB shifted first.
- `rsp_valid` output, 1 bit: the response is available.
- `rsp_ready` input, 1 bit: the consumer accepts the response.
- `rsp_data` output, MAX_BITS: captured TDO bits, LSB first.
- `jtag_tck` output, 1 bit: JTAG TCK.
- `jtag_tms` output, 1 bit: JTAG TMS.
- `jtag_tdi` output, 1 bit: JTAG TDI.
- `jtag_tdo` input, 1 bit: JTAG TDO from the target.

## Operation
- A command is accepted on any cycle with `cmd_valid && cmd_ready`. `cmd_ready` is high only in S_IDLE.
- All ops start from and end in Run-Test/Idle. TAP_RESET is the exception at the start: it works from any TAP state.
- TMS sequences, one entry per TCK:
  - TAP_RESET: 1,1,1,1,1,0, for T = 6. `cmd_len` and `cmd_data` are ignored.
  - SHIFT_DR: header 1,0,0; then L shift bits with TMS=0, except the last bit, which has TMS=1; trailer 1,0. T = L+5.
  - SHIFT_IR: header 1,1,0,0; then L shift bits as for SHIFT_DR; trailer 1,0. T = L+6.
  - RUN_IDLE: L TCKs with TMS=0. T = L. L=0 is legal and produces no TCK.
- Shift length clamping for SHIFT ops: L = `cmd_len`, with 0 treated as 1 and values above MAX_BITS treated as MAX_BITS.
- TDI is `cmd_data[i]` during shift bit i and 0 in all other TCKs.
- TDO is sampled at the rising TCK edge of shift bit i into `rsp_data[i]`. Bits at index L and above are 0.
- `rsp_data` is 0 for TAP_RESET and RUN_IDLE.
- State machine:
  - S_IDLE → S_HEAD on accept; goes instead to S_TAIL for TAP_RESET and RUN_IDLE, which are handled as a pure TMS list.
  - S_HEAD → S_SHIFT → S_TAIL.
  - S_TAIL → S_RSP.
  - S_RSP → S_IDLE on `rsp_valid && rsp_ready`.
- `rsp_valid` is held, and `rsp_data` is stable, until the response handshake completes. No new command is accepted while in S_RSP.
- Between commands, TCK=0, TMS keeps its last value (0 after any completed op), and TDI=0.

## Timing
- Reset values: `jtag_tck`=0, `jtag_tms`=1, `jtag_tdi`=0, `cmd_ready`=1, `rsp_valid`=0, `rsp_data`=0, state = S_IDLE.
- TCK period is 2·CLK_DIV sys cycles: low phase first, then high phase.
- TMS and TDI change only on the cycle TCK falls, or on the first cycle of the low phase of the first TCK.
- Take the accept cycle as cycle 0:
  - The first TCK low phase begins at cycle 1.
  - TCK rising edge k (k from 0) occurs at cycle 1 + CLK_DIV + 2·CLK_DIV·k.
  - The final falling edge occurs at cycle 1 + 2·CLK_DIV·T.
  - `rsp_valid` rises on that same cycle.
- RUN_IDLE with L=0: `rsp_valid` rises at cycle 1.
- A response handshake at cycle c gives `cmd_ready`=1 at cycle c+1.
- Reset asserted mid-command: all outputs return to their reset values asynchronously and the command is dropped. The TAP state is then undefined; the host must issue TAP_RESET.

## Structure
- `jtag_master_pkg` holds:
  - the op enum (TAP_RESET, SHIFT_IR, SHIFT_DR, RUN_IDLE);
  - the state enum (S_IDLE, S_HEAD, S_SHIFT, S_TAIL, S_RSP);
  - header/trailer TMS constants (DR header 3'b001 sent LSB first, IR header 4'b0011, trailer 2'b01, reset 6'b011111);
  - the length-clamp function.
- One sub-module, `jtag_tck_gen`: divider plus phase flag. It produces single-cycle `rise` and `fall` strobes while enabled and holds TCK low when disabled.

## Test plan
- TAP_RESET with CLK_DIV=2 → TMS pattern 1,1,1,1,1,0 sampled on 6 rising edges; `rsp_valid` at cycle 25; `rsp_data`=0.
- SHIFT_IR, L=5, data 0x11, against a behavioral TAP model whose IR captures 0b00001 → model IR=0x11; `rsp_data`=0x01; exactly 11 TCKs.
- SHIFT_DR, L=32, data 0, after IR=IDCODE → `rsp_data`=model IDCODE 0x10002FFF; TMS=1 on the last shift edge only.
- SHIFT_DR with `cmd_len`=0, then `cmd_len`=100 → lengths 1 and 64 respectively; TCK counts 6 and 69.
- RUN_IDLE, L=0 → `rsp_valid` at cycle 1 with no TCK edge. RUN_IDLE, L=3 → 3 TCKs with TMS=0.
- Hold `rsp_ready`=0 for 10 cycles while driving `cmd_valid`=1 → `cmd_ready` stays 0 and `rsp_data` is stable. Then assert reset mid SHIFT_DR → TCK=0 and TMS=1 immediately, `cmd_ready`=1 after release.
